// File: rtl/mmio_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
package mmio_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  localparam logic [31:0] UART_TX_ADDR   = 32'h0000_00C0;
  localparam logic [31:0] UART_STAT_ADDR = 32'h0000_00C4;

  // Bit positions inside the status word
  localparam int BUSY = 0;
  localparam int FULL = 1;
  localparam int OVF  = 2;

endpackage

// File: rtl/byte_fifo.sv
// Small byte FIFO with naturally wrapping pointers and an explicit count.
module byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic [7:0]                   din,
  output logic [7:0]                   dout,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  // Fullness/emptiness are judged on the pre-edge count
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign dout    = mem[rptr];

  // Storage array: data only, never reset
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  // Pointers and occupancy count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Store-snooping 8N1 UART transmitter with a byte FIFO and a status word.
module uart_tx_mmio
  import mmio_pkg::*;
#(
  parameter int          CLK_DIV    = 16,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] TX_ADDR    = UART_TX_ADDR,
  parameter logic [31:0] STAT_ADDR  = UART_STAT_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic        tx,
  output logic [31:0] StatusData,
  output logic        busy,
  output logic        full
);

  localparam int BW = $clog2(CLK_DIV);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLK_DIV - 1);

  uart_state_t   state, state_n;
  logic [BW-1:0] baud, baud_n;
  logic [2:0]    bit_idx, bit_n;
  logic [7:0]    shift, shift_n;
  logic          tx_n;
  logic          overflow;
  logic          pop;
  logic          push_req;
  logic          clr_req;
  logic          empty;
  logic          baud_end;
  logic [7:0]    head;
  logic [CW-1:0] count;

  assign push_req = MemWrite && (DataAdr == TX_ADDR);
  assign clr_req  = MemWrite && (DataAdr == STAT_ADDR);
  assign baud_end = (baud == BAUD_MAX);
  assign busy     = (state != IDLE) || (count != '0);

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_req),
    .pop   (pop),
    .din   (WriteData[7:0]),
    .dout  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // Next-state, baud/bit sequencing and next line level
  always_comb begin
    state_n = state;
    baud_n  = baud;
    bit_n   = bit_idx;
    shift_n = shift;
    tx_n    = tx;
    pop     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_n = head;
          state_n = START;
          baud_n  = '0;
          tx_n    = 1'b0;
        end
      end
      START: begin
        if (baud_end) begin
          state_n = DATA;
          baud_n  = '0;
          bit_n   = 3'd0;
          tx_n    = shift[0];
        end else begin
          baud_n = baud + 1'b1;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_n  = '0;
          shift_n = {1'b0, shift[7:1]};
          if (bit_idx == 3'd7) begin
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            bit_n = bit_idx + 3'd1;
            tx_n  = shift[1];
          end
        end else begin
          baud_n = baud + 1'b1;
        end
      end
      STOP: begin
        if (baud_end) begin
          state_n = IDLE;
          baud_n  = '0;
          tx_n    = 1'b1;
        end else begin
          baud_n = baud + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Transmitter registers; the line is registered so it never glitches
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= 3'd0;
      shift   <= 8'd0;
      tx      <= 1'b1;
    end else begin
      state   <= state_n;
      baud    <= baud_n;
      bit_idx <= bit_n;
      shift   <= shift_n;
      tx      <= tx_n;
    end
  end

  // Sticky overflow: set by a push into a full FIFO, cleared by a status store
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (push_req && full) begin
      overflow <= 1'b1;
    end else if (clr_req) begin
      overflow <= 1'b0;
    end
  end

  // Status word assembled from live register state
  always_comb begin
    StatusData       = '0;
    StatusData[BUSY] = busy;
    StatusData[FULL] = full;
    StatusData[OVF]  = overflow;
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio: frame-level reference model,
// independent line decoder, table-driven sequences and random stores.
module tb_uart_tx_mmio;

  localparam int CD    = 4;
  localparam int FD    = 4;
  localparam int FRAME = 10 * CD;
  localparam logic [31:0] TXA = 32'h0000_00C0;
  localparam logic [31:0] STA = 32'h0000_00C4;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic        tx;
  logic [31:0] StatusData;
  logic        busy;
  logic        full;

  always #5 clk = ~clk;

  uart_tx_mmio #(
    .CLK_DIV   (CD),
    .FIFO_DEPTH(FD),
    .TX_ADDR   (TXA),
    .STAT_ADDR (STA)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .DataAdr   (DataAdr),
    .WriteData (WriteData),
    .tx        (tx),
    .StatusData(StatusData),
    .busy      (busy),
    .full      (full)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: pending bytes, byte on the wire, cycles left in frame
  logic [7:0] m_q[$];
  logic [7:0] m_sent[$];
  logic [7:0] m_cur;
  int         m_timer;
  bit         m_ovf;

  // Line decoder, independent of the model
  bit         rx_act;
  int         rx_cyc;
  logic [7:0] rx_byte;
  logic [7:0] rx_q[$];
  logic       rx_bits[$];
  int         rx_starts[$];
  bit         full_seen;

  typedef struct {
    bit          we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [31:0] exp_stat;
  } vec_t;

  vec_t ovf_tbl[7];
  vec_t adr_tbl[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic m_tx();
    int k;
    if (m_timer == 0) return 1'b1;
    k = (FRAME - m_timer) / CD;
    if (k == 0) return 1'b0;
    if (k <= 8) return m_cur[k-1];
    return 1'b1;
  endfunction

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s    = '0;
    s[0] = (m_timer > 0) || (m_q.size() > 0);
    s[1] = (m_q.size() == FD);
    s[2] = m_ovf;
    return s;
  endfunction

  task automatic model_edge(input bit we, input logic [31:0] a, input logic [31:0] d);
    bit was_full;
    was_full = (m_q.size() == FD);
    if (m_timer > 0) begin
      m_timer--;
    end else if (m_q.size() > 0) begin
      m_cur   = m_q.pop_front();
      m_sent.push_back(m_cur);
      m_timer = FRAME;
    end
    if (we && a == TXA) begin
      if (was_full) m_ovf = 1'b1;
      else          m_q.push_back(d[7:0]);
    end else if (we && a == STA) begin
      m_ovf = 1'b0;
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_sent.delete();
    m_timer = 0;
    m_ovf   = 1'b0;
    rx_act  = 1'b0;
    rx_q.delete();
    rx_bits.delete();
    rx_starts.delete();
  endtask

  task automatic rx_sample();
    int k;
    if (!rx_act) begin
      if (tx === 1'b0) begin
        rx_act = 1'b1;
        rx_cyc = 0;
        rx_starts.push_back(cyc);
      end
    end else begin
      rx_cyc++;
    end
    if (rx_act && (rx_cyc % CD) == CD / 2) begin
      k = rx_cyc / CD;
      rx_bits.push_back(tx);
      if (k >= 1 && k <= 8) rx_byte[k-1] = tx;
      if (k == 9) begin
        rx_act = 1'b0;
        check("stop_bit", {31'b0, tx}, 32'd1);
        rx_q.push_back(rx_byte);
      end
    end
  endtask

  // One clock: drive inputs, let the edge happen, compare against the model
  task automatic step(input bit we, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] s;
    MemWrite  = we;
    DataAdr   = a;
    WriteData = d;
    @(posedge clk);
    cyc++;
    model_edge(we, a, d);
    #1;
    s = m_status();
    check("tx", {31'b0, tx}, {31'b0, m_tx()});
    check("status", StatusData, s);
    check("busy", {31'b0, busy}, {31'b0, s[0]});
    check("full", {31'b0, full}, {31'b0, s[1]});
    if (full) full_seen = 1'b1;
    rx_sample();
    MemWrite = 1'b0;
  endtask

  task automatic drain();
    int i;
    i = 0;
    while ((m_timer > 0 || m_q.size() > 0 || rx_act) && i < 3000) begin
      step(1'b0, 32'h0, 32'h0);
      i++;
    end
    check("drain_timeout", {31'b0, (m_timer > 0 || m_q.size() > 0 || rx_act)}, 32'd0);
    repeat (3) step(1'b0, 32'h0, 32'h0);
  endtask

  // Asynchronous reset asserted mid-cycle, held for n cycles
  task automatic reset_pulse(input int n);
    MemWrite = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("rst_tx", {31'b0, tx}, 32'd1);
    check("rst_status", StatusData, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    model_reset();
    repeat (n) begin
      @(posedge clk);
      cyc++;
      #1;
      check("rst_hold_tx", {31'b0, tx}, 32'd1);
      check("rst_hold_status", StatusData, 32'd0);
    end
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic check_rx(input string name, input logic [7:0] exp[$]);
    check({name, "_count"}, rx_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < rx_q.size(); i++)
      check({name, "_byte"}, {24'b0, rx_q[i]}, {24'b0, exp[i]});
  endtask

  initial begin
    logic       a5_bits[10];
    logic [7:0] exp_b[$];
    int         w;
    logic [31:0] ra;

    a5_bits = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    ovf_tbl[0] = '{1'b1, TXA, 32'h01, 32'h1};
    ovf_tbl[1] = '{1'b1, TXA, 32'h02, 32'h1};
    ovf_tbl[2] = '{1'b1, TXA, 32'h03, 32'h1};
    ovf_tbl[3] = '{1'b1, TXA, 32'h04, 32'h1};
    ovf_tbl[4] = '{1'b1, TXA, 32'h05, 32'h3};
    ovf_tbl[5] = '{1'b1, TXA, 32'h06, 32'h7};
    ovf_tbl[6] = '{1'b1, STA, 32'h00, 32'h3};

    adr_tbl[0] = '{1'b1, 32'h64, 32'hAA, 32'h0};
    adr_tbl[1] = '{1'b1, 32'hC8, 32'hBB, 32'h0};
    adr_tbl[2] = '{1'b1, STA,    32'h5A, 32'h0};
    adr_tbl[3] = '{1'b0, TXA,    32'h77, 32'h0};

    MemWrite  = 1'b0;
    DataAdr   = '0;
    WriteData = '0;
    full_seen = 1'b0;
    reset     = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1;

    // Reset while idle, held 50 cycles
    reset_pulse(50);

    // Single byte 0xA5
    model_reset();
    step(1'b1, TXA, 32'h0000_00A5);
    drain();
    check("a5_nbits", rx_bits.size(), 10);
    for (int i = 0; i < 10 && i < rx_bits.size(); i++)
      check("a5_bit", {31'b0, rx_bits[i]}, {31'b0, a5_bits[i]});
    exp_b = '{8'hA5};
    check_rx("single", exp_b);
    check("single_busy_low", {31'b0, busy}, 32'd0);

    // Back-to-back frames
    model_reset();
    full_seen = 1'b0;
    step(1'b1, TXA, 32'h55);
    step(1'b1, TXA, 32'h0F);
    step(1'b1, TXA, 32'hF0);
    drain();
    exp_b = '{8'h55, 8'h0F, 8'hF0};
    check_rx("b2b", exp_b);
    check("b2b_full_never", {31'b0, full_seen}, 32'd0);
    check("b2b_nstarts", rx_starts.size(), 3);
    for (int i = 1; i < rx_starts.size(); i++)
      check("b2b_gap", rx_starts[i] - rx_starts[i-1], FRAME + 1);

    // Overflow sequence
    model_reset();
    for (int i = 0; i < 7; i++) begin
      step(ovf_tbl[i].we, ovf_tbl[i].adr, ovf_tbl[i].dat);
      check("ovf_tbl", StatusData, ovf_tbl[i].exp_stat);
    end
    drain();
    exp_b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    check_rx("ovf", exp_b);

    // Address filter
    model_reset();
    for (int i = 0; i < 4; i++) begin
      step(adr_tbl[i].we, adr_tbl[i].adr, adr_tbl[i].dat);
      check("adr_tbl", StatusData, adr_tbl[i].exp_stat);
    end
    repeat (50) step(1'b0, 32'h0, 32'h0);
    check("adr_no_frame", rx_q.size() + rx_starts.size(), 0);

    // Reset during data bit 3 with two bytes still queued
    model_reset();
    step(1'b1, TXA, 32'h11);
    step(1'b1, TXA, 32'h22);
    step(1'b1, TXA, 32'h33);
    w = 0;
    while (!(m_timer > 0 && (FRAME - m_timer) / CD == 4) && w < 100) begin
      step(1'b0, 32'h0, 32'h0);
      w++;
    end
    check("mid_reach_bit3", {31'b0, (m_timer > 0 && (FRAME - m_timer) / CD == 4)}, 32'd1);
    reset_pulse(2);
    repeat (100) step(1'b0, 32'h0, 32'h0);
    check("mid_no_frames", rx_q.size() + rx_starts.size(), 0);
    check("mid_busy", {31'b0, busy}, 32'd0);

    // Random stores against the model
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 4))
        0, 1:    ra = TXA;
        2:       ra = STA;
        3:       ra = 32'hC8;
        default: ra = $urandom;
      endcase
      step(($urandom_range(0, 3) == 0), ra, $urandom);
    end
    drain();
    exp_b = m_sent;
    check_rx("rand", exp_b);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
